// File: rtl/tune_pkg.sv
// Shared types and constants for the tune sequencer: FSM states, song ROM word
// layout and the note divider table used when building song ROMs.
package tune_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_PAUSE
    } state_t;

    localparam int TIMER_W    = 28;
    localparam int TONE_DIV_W = 17;

    // rom_data = {dur[3:0], div[TONE_DIV_W-1:0]}
    localparam int DIV_LSB = 0;
    localparam int DIV_MSB = TONE_DIV_W - 1;
    localparam int DUR_LSB = TONE_DIV_W;
    localparam int DUR_MSB = TONE_DIV_W + 3;

    localparam logic [TONE_DIV_W-1:0] REST_DIV = '0;
    localparam logic [3:0]            END_DUR  = 4'd0;

    // Half-period counts at 50 MHz, E4 up to C6
    localparam logic [TONE_DIV_W-1:0] L_3 = 17'd75843;
    localparam logic [TONE_DIV_W-1:0] L_4 = 17'd71586;
    localparam logic [TONE_DIV_W-1:0] L_5 = 17'd63776;
    localparam logic [TONE_DIV_W-1:0] L_6 = 17'd56818;
    localparam logic [TONE_DIV_W-1:0] L_7 = 17'd50619;
    localparam logic [TONE_DIV_W-1:0] M_1 = 17'd47778;
    localparam logic [TONE_DIV_W-1:0] M_2 = 17'd42566;
    localparam logic [TONE_DIV_W-1:0] M_3 = 17'd37922;
    localparam logic [TONE_DIV_W-1:0] M_4 = 17'd35793;
    localparam logic [TONE_DIV_W-1:0] M_5 = 17'd31888;
    localparam logic [TONE_DIV_W-1:0] M_6 = 17'd28409;
    localparam logic [TONE_DIV_W-1:0] M_7 = 17'd25310;
    localparam logic [TONE_DIV_W-1:0] H_1 = 17'd23889;

endpackage

// File: rtl/beat_timer.sv
// Down-counter shared by the PLAY and GAP phases. The expire pulse is
// registered one count early so it is high during the final counted cycle.
module beat_timer
    import tune_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            expire <= (load_val == W'(1));
        end else if (!hold) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            expire <= (cnt == W'(2));
        end
    end

endmodule

// File: rtl/tune_sequencer.sv
// Song ROM sequencer: walks the ROM note by note, drives the tone generator
// divider/enable and times each note in beats with a trailing silent gap.
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_000_000,
    parameter int GAP_CYCLES  = 500_000,
    parameter int ADDR_W      = 6,
    parameter int DIV_W       = TONE_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DIV_W+3:0]  rom_data,
    output logic [DIV_W-1:0]  tone_div,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam logic [TIMER_W-1:0] GAP_LEN = TIMER_W'(GAP_CYCLES);

    state_t state, state_nxt, saved, saved_nxt;
    logic   pend, pend_nxt, end_song;
    logic   [ADDR_W-1:0]  addr_nxt;
    logic   [DIV_W-1:0]   div_nxt;
    logic   tone_en_nxt, done_nxt;
    logic   tmr_load, tmr_expire;
    logic   [TIMER_W-1:0] tmr_val, play_len;
    logic   [3:0]         rom_dur;
    logic   [DIV_W-1:0]   rom_div;

    assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];
    assign rom_div  = rom_data[DIV_MSB:DIV_LSB];
    // 28-bit product: 15 beats of 12e6 cycles still fits
    assign play_len = TIMER_W'(rom_dur) * TIMER_W'(BEAT_CYCLES) - GAP_LEN;

    beat_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (state == S_PAUSE),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            saved    <= S_PLAY;
            pend     <= 1'b0;
            rom_addr <= '0;
            tone_div <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            saved    <= saved_nxt;
            pend     <= pend_nxt;
            rom_addr <= addr_nxt;
            tone_div <= div_nxt;
            tone_en  <= tone_en_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        saved_nxt = saved;
        pend_nxt  = pend;
        end_song  = 1'b0;
        if (stop) begin
            state_nxt = S_IDLE;
            pend_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_FETCH;
                S_FETCH: begin
                    state_nxt = S_LOAD;
                    if (pause) pend_nxt = 1'b1;
                end
                S_LOAD: begin
                    if (rom_dur == END_DUR) begin
                        end_song  = 1'b1;
                        state_nxt = loop_en ? S_FETCH : S_IDLE;
                        pend_nxt  = loop_en & (pend | pause);
                    end else if (pend || pause) begin
                        state_nxt = S_PAUSE;
                        saved_nxt = S_PLAY;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tmr_expire) begin
                        state_nxt = S_GAP;
                    end else if (pause) begin
                        state_nxt = S_PAUSE;
                        saved_nxt = S_PLAY;
                    end
                end
                S_GAP: begin
                    if (tmr_expire) begin
                        if (&rom_addr) begin
                            end_song  = 1'b1;
                            state_nxt = loop_en ? S_FETCH : S_IDLE;
                        end else begin
                            state_nxt = S_FETCH;
                        end
                    end else if (pause) begin
                        state_nxt = S_PAUSE;
                        saved_nxt = S_GAP;
                    end
                end
                S_PAUSE: if (pause) state_nxt = saved;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_nxt = rom_addr;
        div_nxt  = tone_div;
        tmr_load = 1'b0;
        tmr_val  = play_len;
        if (state == S_LOAD && !end_song && !stop) begin
            div_nxt  = rom_div;
            tmr_load = 1'b1;
        end
        if (state == S_PLAY && state_nxt == S_GAP) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LEN;
        end
        if (state_nxt == S_IDLE || end_song || state == S_IDLE)
            addr_nxt = '0;
        else if (state == S_GAP && state_nxt == S_FETCH)
            addr_nxt = rom_addr + 1'b1;
        tone_en_nxt = (state_nxt == S_PLAY) && (div_nxt != REST_DIV);
        done_nxt    = end_song && !loop_en;
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with short beats (100 cycles, 10-cycle gap)
// and a registered song ROM model.
module tb_tune_sequencer;
    import tune_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [5:0]  rom_addr;
    logic [20:0] rom_data;
    logic [16:0] tone_div;
    logic        tone_en, busy, done;

    logic [20:0] rom [64];
    logic [16:0] notes [13];

    int n_cmp = 0, n_bad = 0;
    int cyc, en_cnt, first_en, last_en, busy_cnt, done_cnt, done_cyc;

    tune_sequencer #(.BEAT_CYCLES(100), .GAP_CYCLES(10), .ADDR_W(6), .DIV_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tone_div(tone_div), .tone_en(tone_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_stats();
        en_cnt = 0; first_en = -1; last_en = -1;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (tone_en === 1'b1) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        start = 0; pause = 0; stop = 0; loop_en = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 21'd0;
    endtask

    task automatic begin_song();
        cyc = 0;
        clear_stats();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        n_cmp++; if (tone_div !== 17'd0) begin n_bad++; $display("FAIL reset_tone_div: got %0d expected 0", tone_div); end
        n_cmp++; if (tone_en !== 1'b0) begin n_bad++; $display("FAIL reset_tone_en: got %0b expected 0", tone_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    endtask

    task automatic test_single_note();
        do_reset();
        clear_rom();
        rom[0] = {4'd2, 17'd47774};
        begin_song();
        run(219);
        n_cmp++; if (first_en != 3) begin n_bad++; $display("FAIL single_first_en: got %0d expected 3", first_en); end
        n_cmp++; if (last_en != 192) begin n_bad++; $display("FAIL single_last_en: got %0d expected 192", last_en); end
        n_cmp++; if (en_cnt != 190) begin n_bad++; $display("FAIL single_en_cnt: got %0d expected 190", en_cnt); end
        n_cmp++; if (tone_div !== 17'd47774) begin n_bad++; $display("FAIL single_tone_div: got %0d expected 47774", tone_div); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc != 205) begin n_bad++; $display("FAIL single_done_cyc: got %0d expected 205", done_cyc); end
        n_cmp++; if (busy_cnt != 204) begin n_bad++; $display("FAIL single_busy_cnt: got %0d expected 204", busy_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
    endtask

    task automatic test_rest();
        do_reset();
        clear_rom();
        rom[0] = {4'd1, 17'd0};
        begin_song();
        run(119);
        n_cmp++; if (en_cnt != 0) begin n_bad++; $display("FAIL rest_en_cnt: got %0d expected 0", en_cnt); end
        n_cmp++; if (busy_cnt != 104) begin n_bad++; $display("FAIL rest_busy_cnt: got %0d expected 104", busy_cnt); end
        n_cmp++; if (done_cyc != 105) begin n_bad++; $display("FAIL rest_done_cyc: got %0d expected 105", done_cyc); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        clear_rom();
        rom[0] = {4'd2, 17'd47774};
        begin_song();
        run(51);
        n_cmp++; if (en_cnt != 50) begin n_bad++; $display("FAIL pause_pre_en_cnt: got %0d expected 50", en_cnt); end
        clear_stats();
        pause = 1;
        step();
        pause = 0;
        n_cmp++; if (tone_en !== 1'b0) begin n_bad++; $display("FAIL pause_tone_en: got %0b expected 0", tone_en); end
        run(299);
        n_cmp++; if (en_cnt != 0) begin n_bad++; $display("FAIL pause_hold_en_cnt: got %0d expected 0", en_cnt); end
        n_cmp++; if (busy_cnt != 300) begin n_bad++; $display("FAIL pause_hold_busy: got %0d expected 300", busy_cnt); end
        n_cmp++; if (tone_div !== 17'd47774) begin n_bad++; $display("FAIL pause_tone_div: got %0d expected 47774", tone_div); end
        clear_stats();
        pause = 1;
        step();
        pause = 0;
        run(157);
        n_cmp++; if (en_cnt != 140) begin n_bad++; $display("FAIL resume_en_cnt: got %0d expected 140", en_cnt); end
        n_cmp++; if (first_en != 353) begin n_bad++; $display("FAIL resume_first_en: got %0d expected 353", first_en); end
        n_cmp++; if (last_en != 492) begin n_bad++; $display("FAIL resume_last_en: got %0d expected 492", last_en); end
        n_cmp++; if (done_cyc != 505) begin n_bad++; $display("FAIL resume_done_cyc: got %0d expected 505", done_cyc); end
    endtask

    task automatic test_loop_wrap();
        notes = '{L_3, L_4, L_5, L_6, L_7, M_1, M_2, M_3, M_4, M_5, M_6, M_7, H_1};
        do_reset();
        for (int i = 0; i < 64; i++) rom[i] = {4'd1, notes[i % 13]};
        loop_en = 1;
        begin_song();
        run(512);
        n_cmp++; if (tone_div !== notes[5]) begin n_bad++; $display("FAIL loop_note5_div: got %0d expected %0d", tone_div, notes[5]); end
        n_cmp++; if (rom_addr !== 6'd5) begin n_bad++; $display("FAIL loop_note5_addr: got %0d expected 5", rom_addr); end
        run(6528 - 513);
        n_cmp++; if (rom_addr !== 6'd63) begin n_bad++; $display("FAIL loop_last_addr: got %0d expected 63", rom_addr); end
        step();
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL loop_wrap_addr: got %0d expected 0", rom_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL loop_wrap_busy: got %0b expected 1", busy); end
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL loop_no_done: got %0d expected 0", done_cnt); end
        run(2);
        n_cmp++; if (tone_en !== 1'b1 || tone_div !== notes[0]) begin n_bad++; $display("FAIL loop_replay: got en=%0b div=%0d expected en=1 div=%0d", tone_en, tone_div, notes[0]); end
        loop_en = 0;
        clear_stats();
        run(13060 - 6531);
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL noloop_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc != 13057) begin n_bad++; $display("FAIL noloop_done_cyc: got %0d expected 13057", done_cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noloop_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_stop_priority();
        do_reset();
        clear_rom();
        rom[0] = {4'd1, M_1};
        rom[1] = {4'd2, H_1};
        begin_song();
        run(49);
        start = 1;
        step();
        start = 0;
        run(69);
        n_cmp++; if (rom_addr !== 6'd1) begin n_bad++; $display("FAIL ignore_start_addr: got %0d expected 1", rom_addr); end
        n_cmp++; if (tone_div !== H_1 || tone_en !== 1'b1) begin n_bad++; $display("FAIL ignore_start_tone: got en=%0b div=%0d expected en=1 div=%0d", tone_en, tone_div, H_1); end
        run(30);
        stop = 1;
        start = 1;
        step();
        stop = 0;
        start = 0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        n_cmp++; if (tone_en !== 1'b0) begin n_bad++; $display("FAIL stop_tone_en: got %0b expected 0", tone_en); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL stop_rom_addr: got %0d expected 0", rom_addr); end
        clear_stats();
        run(30);
        n_cmp++; if (busy_cnt != 0 || done_cnt != 0) begin n_bad++; $display("FAIL stop_stays_idle: got busy_cnt=%0d done_cnt=%0d expected 0 0", busy_cnt, done_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        clear_rom();
        rom[0] = {4'd1, M_1};
        rom[1] = {4'd2, H_1};
        begin_song();
        run(299);
        n_cmp++; if (busy !== 1'b1 || rom_addr !== 6'd1 || tone_en !== 1'b0) begin n_bad++; $display("FAIL areset_pre_gap: got busy=%0b addr=%0d en=%0b expected 1 1 0", busy, rom_addr, tone_en); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL areset_rom_addr: got %0d expected 0", rom_addr); end
        n_cmp++; if (tone_div !== 17'd0) begin n_bad++; $display("FAIL areset_tone_div: got %0d expected 0", tone_div); end
        n_cmp++; if (busy !== 1'b0 || tone_en !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got busy=%0b en=%0b done=%0b expected 0 0 0", busy, tone_en, done); end
        @(negedge clk);
        rst_n = 1;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_idle_after: got %0b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_rest();
        test_pause_resume();
        test_loop_wrap();
        test_stop_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
